// File: rtl/free_list_nway.sv
// N-way physical-register free list: a circular FIFO of free tags with multi-slot alloc/free.
// Optional branch checkpoint/recover of the head pointer is enabled by defining FL_RECOVER_EN.
module free_list_nway #(
  parameter int PREG_NUM = 96,
  parameter int ARCH_NUM = 32,
  parameter int TAG_W    = 7,
  parameter int WAY      = 2,
  localparam int DEPTH   = PREG_NUM - ARCH_NUM,
  localparam int CNT_W   = $clog2(DEPTH + 1),
  localparam int NUM_W   = $clog2(WAY + 1)
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic [NUM_W-1:0]       id_dispatch_num,
  input  logic [NUM_W-1:0]       rob_retire_num,
  input  logic [WAY*TAG_W-1:0]   rob_retire_tags,
`ifdef FL_RECOVER_EN
  input  logic                   br_checkpoint,
  input  logic                   br_recover,
`endif
  output logic [WAY*TAG_W-1:0]   fl_pr_tags,
  output logic [WAY-1:0]         fl_pr_valid,
  output logic                   fl_stall,
  output logic [CNT_W-1:0]       fl_free_count,
  output logic                   fl_overflow
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int EW    = CNT_W + 2;

  // Modulo-DEPTH increment; DEPTH need not be a power of two.
  function automatic logic [PTR_W-1:0] ptr_add(input logic [PTR_W-1:0] p, input logic [EW-1:0] n);
    logic [EW-1:0] s;
    s = EW'(p) + n;
    if (s >= EW'(DEPTH)) s = s - EW'(DEPTH);
    return PTR_W'(s);
  endfunction

  logic [TAG_W-1:0] mem_reg [DEPTH];
  logic [PTR_W-1:0] head_reg, tail_reg, tail_next;
  logic [CNT_W-1:0] count_reg, count_next;
  logic             overflow_reg;
  logic [EW-1:0]    disp_n, ret_n, granted, room, freed, count_ext;
  logic             stall, recover;

  logic [PTR_W-1:0] rd_idx [WAY];
  logic [PTR_W-1:0] wr_idx [WAY];
  logic [WAY-1:0]   wr_en;

`ifdef FL_RECOVER_EN
  logic [PTR_W-1:0] ckpt_reg;
  logic             ckpt_full_reg;
  logic [EW-1:0]    rec_diff;
  logic [CNT_W-1:0] rec_count;
  assign recover = br_recover;
`else
  assign recover = 1'b0;
`endif

  always_comb begin
    disp_n = EW'(id_dispatch_num);
    if (disp_n > EW'(WAY)) disp_n = EW'(WAY);
    ret_n = EW'(rob_retire_num);
    if (ret_n > EW'(WAY)) ret_n = EW'(WAY);
    count_ext  = EW'(count_reg);
    stall      = !recover && (disp_n > count_ext);
    granted    = (stall || recover) ? '0 : disp_n;
    // Frees that would push the count past DEPTH are dropped.
    room       = EW'(DEPTH) - count_ext + granted;
    freed      = (ret_n > room) ? room : ret_n;
    count_next = CNT_W'(count_ext - granted + freed);
    tail_next  = ptr_add(tail_reg, freed);
  end

`ifdef FL_RECOVER_EN
  always_comb begin
    rec_diff = (tail_next >= ckpt_reg) ? (EW'(tail_next) - EW'(ckpt_reg))
                                       : (EW'(tail_next) + EW'(DEPTH) - EW'(ckpt_reg));
    rec_count = (rec_diff == '0 && ckpt_full_reg) ? CNT_W'(DEPTH) : CNT_W'(rec_diff);
  end
`endif

  for (genvar gi = 0; gi < WAY; gi++) begin : g_slot
    assign rd_idx[gi] = ptr_add(head_reg, EW'(gi));
    assign wr_idx[gi] = ptr_add(tail_reg, EW'(gi));
    assign wr_en[gi]  = EW'(gi) < freed;
    assign fl_pr_valid[gi] = !reset && (EW'(gi) < granted);
    assign fl_pr_tags[gi*TAG_W +: TAG_W] = fl_pr_valid[gi] ? mem_reg[rd_idx[gi]] : '0;
  end

  assign fl_stall      = !reset && stall;
  assign fl_free_count = count_reg;
  assign fl_overflow   = overflow_reg;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) mem_reg[i] <= TAG_W'(ARCH_NUM + i);
      head_reg     <= '0;
      tail_reg     <= '0;
      count_reg    <= CNT_W'(DEPTH);
      overflow_reg <= 1'b0;
    end else begin
      for (int k = 0; k < WAY; k++) begin
        if (wr_en[k]) mem_reg[wr_idx[k]] <= rob_retire_tags[k*TAG_W +: TAG_W];
      end
      tail_reg     <= tail_next;
      overflow_reg <= overflow_reg | (ret_n > room);
`ifdef FL_RECOVER_EN
      head_reg  <= recover ? ckpt_reg : ptr_add(head_reg, granted);
      count_reg <= recover ? rec_count : count_next;
`else
      head_reg  <= ptr_add(head_reg, granted);
      count_reg <= count_next;
`endif
    end
  end

`ifdef FL_RECOVER_EN
  // The checkpoint captures the pre-edge head; a same-cycle recover still sees the old value.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      ckpt_reg      <= '0;
      ckpt_full_reg <= 1'b1;
    end else if (br_checkpoint) begin
      ckpt_reg      <= head_reg;
      ckpt_full_reg <= (count_reg == CNT_W'(DEPTH));
    end
  end
`endif

endmodule

// File: tb/tb_free_list_nway.sv
// Scoreboard bench for free_list_nway: a tag-queue reference model feeds expectations
// to a negedge monitor; directed scenarios first, then randomized traffic.
module tb_free_list_nway;
  localparam int PREG_NUM = 96;
  localparam int ARCH_NUM = 32;
  localparam int TAG_W    = 7;
  localparam int WAY      = 2;
  localparam int DEPTH    = PREG_NUM - ARCH_NUM;
  localparam int CNT_W    = $clog2(DEPTH + 1);
  localparam int NUM_W    = $clog2(WAY + 1);

  logic clock = 1'b0;
  logic reset = 1'b1;
  logic [NUM_W-1:0]     id_dispatch_num = '0;
  logic [NUM_W-1:0]     rob_retire_num  = '0;
  logic [WAY*TAG_W-1:0] rob_retire_tags = '0;
  logic [WAY*TAG_W-1:0] fl_pr_tags;
  logic [WAY-1:0]       fl_pr_valid;
  logic                 fl_stall;
  logic [CNT_W-1:0]     fl_free_count;
  logic                 fl_overflow;
`ifdef FL_RECOVER_EN
  logic br_checkpoint = 1'b0;
  logic br_recover    = 1'b0;
`endif

  always #5 clock = ~clock;

  free_list_nway #(.PREG_NUM(PREG_NUM), .ARCH_NUM(ARCH_NUM), .TAG_W(TAG_W), .WAY(WAY)) dut (
    .clock           (clock),
    .reset           (reset),
    .id_dispatch_num (id_dispatch_num),
    .rob_retire_num  (rob_retire_num),
    .rob_retire_tags (rob_retire_tags),
`ifdef FL_RECOVER_EN
    .br_checkpoint   (br_checkpoint),
    .br_recover      (br_recover),
`endif
    .fl_pr_tags      (fl_pr_tags),
    .fl_pr_valid     (fl_pr_valid),
    .fl_stall        (fl_stall),
    .fl_free_count   (fl_free_count),
    .fl_overflow     (fl_overflow)
  );

  typedef struct {
    int                   id;
    logic [WAY-1:0]       valid;
    logic [WAY*TAG_W-1:0] tags;
    logic                 stall;
    int                   count;
    logic                 ovf;
  } exp_t;

  exp_t sb[$];
  int   free_q[$];
  int   inuse[$];
  int   since_ckpt[$];
  bit   m_ovf;
  int   total = 0;
  int   bad   = 0;
  int   txn   = 0;

  task automatic check(input string name, input int id, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s txn=%0d got=%0h expected=%0h", name, id, act, exp);
    end
  endtask

  task automatic model_reset();
    free_q.delete();
    for (int i = 0; i < DEPTH; i++) free_q.push_back(ARCH_NUM + i);
    inuse.delete();
    since_ckpt.delete();
    m_ovf = 1'b0;
  endtask

  function automatic int take_inuse();
    int idx, t;
    idx = $urandom_range(0, inuse.size() - 1);
    t = inuse[idx];
    inuse.delete(idx);
    return t;
  endfunction

  // One dispatch/retire cycle: drive inputs, predict outputs from the tag queue, advance the model.
  task automatic step(input int dn, input int rn, input int t0 = 0, input int t1 = 0,
                      input bit ck = 1'b0, input bit rc = 1'b0);
    exp_t e;
    int   g, r, room, nfree;
    int   tg[2];
    @(posedge clock); #1;
    reset           = 1'b0;
    id_dispatch_num = NUM_W'(dn);
    rob_retire_num  = NUM_W'(rn);
    rob_retire_tags = {TAG_W'(t1), TAG_W'(t0)};
`ifdef FL_RECOVER_EN
    br_checkpoint = ck;
    br_recover    = rc;
`endif
    tg[0] = t0; tg[1] = t1;
    e.id = txn++; e.valid = '0; e.tags = '0;
    e.count = free_q.size(); e.ovf = m_ovf;
    g = (dn > WAY) ? WAY : dn;
    r = (rn > WAY) ? WAY : rn;
    e.stall = !rc && (g > free_q.size());
    if (rc || e.stall) g = 0;
    if (ck) since_ckpt.delete();
    for (int k = 0; k < g; k++) begin
      int t;
      t = free_q.pop_front();
      e.valid[k] = 1'b1;
      e.tags[k*TAG_W +: TAG_W] = TAG_W'(t);
      inuse.push_back(t);
      since_ckpt.push_back(t);
    end
    if (rc) begin
      for (int i = since_ckpt.size() - 1; i >= 0; i--) free_q.push_front(since_ckpt[i]);
      since_ckpt.delete();
    end
    room  = DEPTH - free_q.size();
    nfree = (r > room) ? room : r;
    if (r > room) m_ovf = 1'b1;
    for (int k = 0; k < nfree; k++) free_q.push_back(tg[k]);
    sb.push_back(e);
  endtask

  // Assert reset mid-cycle while a dispatch is requested; outputs must read as the reset image.
  task automatic do_reset();
    exp_t e;
    @(posedge clock); #1;
    reset = 1'b1;
    id_dispatch_num = NUM_W'(2);
    rob_retire_num  = '0;
    model_reset();
    e.id = txn++; e.valid = '0; e.tags = '0; e.stall = 1'b0; e.count = DEPTH; e.ovf = 1'b0;
    sb.push_back(e);
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clock);
      if (sb.size() > 0) begin
        e = sb.pop_front();
        check("valid", e.id, 64'(fl_pr_valid), 64'(e.valid));
        check("tags",  e.id, 64'(fl_pr_tags),  64'(e.tags));
        check("stall", e.id, 64'(fl_stall),    64'(e.stall));
        check("count", e.id, 64'(fl_free_count), 64'(e.count));
        check("ovf",   e.id, 64'(fl_overflow), 64'(e.ovf));
        $display("txn %0d valid=%b tags=%h stall=%b count=%0d ovf=%b",
                 e.id, fl_pr_valid, fl_pr_tags, fl_stall, fl_free_count, fl_overflow);
      end
    end
  end

  initial begin : watchdog
    #1000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "timeout");
  end

  initial begin : stim
    int a, b, maxr, dn, rn, t0, t1;
    bit heavy;
    // Basic allocation from reset, then count check on the following cycle.
    do_reset();
    step(2, 0);
    step(1, 0);
    step(0, 0);
    // Drain the whole list, then stall on empty.
    do_reset();
    repeat (32) step(2, 0);
    step(1, 0);
    // One free tag with a two-wide request: no partial grant.
    step(0, 1, take_inuse());
    step(2, 0);
    step(1, 0);
    // Frees are not visible until the next cycle.
    step(2, 2, 5, 7);
    step(2, 0);
    step(0, 0);
    // Wrap-around of head past the end of the array.
    do_reset();
    repeat (31) step(2, 0);
    step(1, 0);
    step(0, 2, 32, 33);
    step(0, 1, 34);
    step(2, 0);
    step(0, 0);
    // Overflow: balanced alloc+free on full is legal, a pure free on full is not.
    do_reset();
    step(2, 2, 1, 2);
    step(0, 0);
    step(0, 1, 3);
    step(0, 0);
    step(1, 0);
    step(3, 0);
    step(0, 0);
`ifdef FL_RECOVER_EN
    do_reset();
    repeat (5) step(2, 0);
    step(0, 0, 0, 0, 1'b1, 1'b0);
    repeat (3) step(2, 0);
    step(2, 0, 0, 0, 1'b0, 1'b1);
    step(1, 0);
    step(0, 0);
`endif
    // Randomized traffic with alternating drain/refill phases and a mid-run reset.
    do_reset();
    for (int i = 0; i < 400; i++) begin
      if (i == 200) do_reset();
      heavy = ((i / 40) % 2) == 0;
      maxr  = (inuse.size() < 2) ? inuse.size() : 2;
      dn    = heavy ? $urandom_range(1, 3) : $urandom_range(0, 1);
      rn    = heavy ? $urandom_range(0, (maxr < 1) ? maxr : 1) : $urandom_range(0, maxr);
      if (rn == 2 && $urandom_range(0, 7) == 0) rn = 3;
      a = (rn > 2) ? 2 : rn;
      t0 = 0; t1 = 0;
      if (a >= 1) t0 = take_inuse();
      if (a >= 2) t1 = take_inuse();
      step(dn, rn, t0, t1);
    end
    step(0, 0);
    b = 0;
    repeat (3) begin
      @(posedge clock);
      b++;
    end
    check("sb_drain", txn, 64'(sb.size()), 64'(0));
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
